// File: rtl/ucode_loop_ctrl.sv
// Microcode PC sequencer with three nested zero-overhead hardware loops.
// Level 0 is innermost; levels sharing an end address unwind inner-first in one cycle.
module ucode_loop_ctrl #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned ITER_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  en_i,
  input  logic                  jmp_valid_i,
  input  logic [ADDR_WIDTH-1:0] jmp_target_i,
  input  logic                  setup_valid_i,
  input  logic [1:0]            setup_level_i,
  input  logic [ITER_WIDTH-1:0] setup_iter_i,
  input  logic [ADDR_WIDTH-1:0] setup_end_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [2:0]            loop_active_o,
  output logic                  error_o
);

  localparam int unsigned NumLevels = 3;

  logic [ADDR_WIDTH-1:0]                 pc_q, pc_d;
  logic [NumLevels-1:0]                  active_q, active_d;
  logic [NumLevels-1:0][ADDR_WIDTH-1:0]  start_q, start_d;
  logic [NumLevels-1:0][ADDR_WIDTH-1:0]  end_q, end_d;
  logic [NumLevels-1:0][ITER_WIDTH-1:0]  rem_q, rem_d;
  logic                                  error_q, error_d;

  logic [ADDR_WIDTH-1:0] pc_inc;
  logic                  back_edge;

  assign pc_inc = pc_q + ADDR_WIDTH'(1);

  always_comb begin
    pc_d      = pc_q;
    active_d  = active_q;
    start_d   = start_q;
    end_d     = end_q;
    rem_d     = rem_q;
    error_d   = error_q;
    back_edge = 1'b0;

    if (clear_i) begin
      pc_d     = '0;
      active_d = '0;
      start_d  = '0;
      end_d    = '0;
      rem_d    = '0;
      error_d  = 1'b0;
    end else if (en_i) begin
      if (jmp_valid_i) begin
        // Jump wins over a simultaneous setup; the setup is dropped and flagged.
        pc_d = jmp_target_i;
        if (setup_valid_i) begin
          error_d = 1'b1;
        end
      end else if (setup_valid_i) begin
        if (setup_level_i == 2'd3) begin
          error_d = 1'b1;
          pc_d    = pc_inc;
        end else if (setup_iter_i != '0) begin
          active_d[setup_level_i] = 1'b1;
          start_d[setup_level_i]  = pc_inc;
          end_d[setup_level_i]    = setup_end_i;
          rem_d[setup_level_i]    = setup_iter_i;
          pc_d                    = pc_inc;
          if (setup_end_i < pc_inc) begin
            error_d = 1'b1;
          end
        end else begin
          // Zero iterations: skip the whole body.
          active_d[setup_level_i] = 1'b0;
          rem_d[setup_level_i]    = '0;
          pc_d                    = setup_end_i + ADDR_WIDTH'(1);
        end
      end else begin
        pc_d = pc_inc;
        // Exhausted levels retire and let the next outer level check the same end.
        for (int i = 0; i < NumLevels; i++) begin
          if (!back_edge && active_q[i] && (end_q[i] == pc_q)) begin
            if (rem_q[i] > ITER_WIDTH'(1)) begin
              rem_d[i]  = rem_q[i] - ITER_WIDTH'(1);
              pc_d      = start_q[i];
              back_edge = 1'b1;
            end else begin
              active_d[i] = 1'b0;
              rem_d[i]    = '0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q     <= '0;
      active_q <= '0;
      start_q  <= '0;
      end_q    <= '0;
      rem_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      active_q <= active_d;
      start_q  <= start_d;
      end_q    <= end_d;
      rem_q    <= rem_d;
      error_q  <= error_d;
    end
  end

  assign pc_o          = pc_q;
  assign loop_active_o = active_q;
  assign error_o       = error_q;

endmodule

// File: tb/tb_ucode_loop_ctrl.sv
// Directed bench for ucode_loop_ctrl: loops, nesting, jumps, errors, stalls and wrap.
module tb_ucode_loop_ctrl;

  localparam int unsigned AW = 10;
  localparam int unsigned IW = 10;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          clear_i;
  logic          en_i;
  logic          jmp_valid_i;
  logic [AW-1:0] jmp_target_i;
  logic          setup_valid_i;
  logic [1:0]    setup_level_i;
  logic [IW-1:0] setup_iter_i;
  logic [AW-1:0] setup_end_i;
  logic [AW-1:0] pc_o;
  logic [2:0]    loop_active_o;
  logic          error_o;

  int vectors     = 0;
  int miscompares = 0;

  ucode_loop_ctrl #(
    .ADDR_WIDTH(AW),
    .ITER_WIDTH(IW)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .en_i         (en_i),
    .jmp_valid_i  (jmp_valid_i),
    .jmp_target_i (jmp_target_i),
    .setup_valid_i(setup_valid_i),
    .setup_level_i(setup_level_i),
    .setup_iter_i (setup_iter_i),
    .setup_end_i  (setup_end_i),
    .pc_o         (pc_o),
    .loop_active_o(loop_active_o),
    .error_o      (error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle_inputs();
    clear_i       = 1'b0;
    en_i          = 1'b0;
    jmp_valid_i   = 1'b0;
    jmp_target_i  = '0;
    setup_valid_i = 1'b0;
    setup_level_i = '0;
    setup_iter_i  = '0;
    setup_end_i   = '0;
  endtask

  // One retiring instruction; outputs are sampled 1 time unit after the edge.
  task automatic retire(input logic jv, input logic [AW-1:0] tgt, input logic sv,
                        input logic [1:0] lvl, input logic [IW-1:0] n,
                        input logic [AW-1:0] e);
    @(negedge clk_i);
    en_i          = 1'b1;
    jmp_valid_i   = jv;
    jmp_target_i  = tgt;
    setup_valid_i = sv;
    setup_level_i = lvl;
    setup_iter_i  = n;
    setup_end_i   = e;
    @(posedge clk_i);
    #1;
    idle_inputs();
  endtask

  task automatic plain();
    retire(1'b0, '0, 1'b0, 2'd0, '0, '0);
  endtask

  task automatic do_clear();
    @(negedge clk_i);
    clear_i = 1'b1;
    @(posedge clk_i);
    #1;
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    vectors++;
    if (pc_o !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_pc got %0d want 0", pc_o);
    end
    vectors++;
    if (loop_active_o !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_active got %b want 000", loop_active_o);
    end
    vectors++;
    if (error_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_error got %b want 0", error_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_single_loop();
    int   exp_pc[9]  = '{4, 5, 3, 4, 5, 3, 4, 5, 6};
    logic exp_act[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_clear();
    plain();
    plain();
    vectors++;
    if (pc_o !== 10'd2) begin
      miscompares++;
      $display("FAIL single_pre_pc got %0d want 2", pc_o);
    end
    retire(1'b0, '0, 1'b1, 2'd0, 10'd3, 10'd5);
    vectors++;
    if (pc_o !== 10'd3 || loop_active_o !== 3'b001) begin
      miscompares++;
      $display("FAIL single_setup got pc=%0d act=%b want pc=3 act=001", pc_o, loop_active_o);
    end
    for (int i = 0; i < 9; i++) begin
      plain();
      vectors++;
      if (pc_o !== AW'(exp_pc[i]) || loop_active_o[0] !== exp_act[i]) begin
        miscompares++;
        $display("FAIL single_step%0d got pc=%0d act0=%b want pc=%0d act0=%b",
                 i, pc_o, loop_active_o[0], exp_pc[i], exp_act[i]);
      end
    end
  endtask

  task automatic test_shared_end();
    int exp_seq[14] = '{6, 7, 8, 6, 7, 8, 5, 6, 7, 8, 6, 7, 8, 9};
    int model_pc;
    do_clear();
    repeat (4) plain();
    retire(1'b0, '0, 1'b1, 2'd1, 10'd2, 10'd8);
    vectors++;
    if (pc_o !== 10'd5 || loop_active_o !== 3'b010) begin
      miscompares++;
      $display("FAIL shared_setup1 got pc=%0d act=%b want pc=5 act=010", pc_o, loop_active_o);
    end
    model_pc = 5;
    for (int i = 0; i < 14; i++) begin
      if (model_pc == 5) retire(1'b0, '0, 1'b1, 2'd0, 10'd2, 10'd8);
      else plain();
      vectors++;
      if (pc_o !== AW'(exp_seq[i])) begin
        miscompares++;
        $display("FAIL shared_step%0d got pc=%0d want %0d", i, pc_o, exp_seq[i]);
      end
      if (i == 6) begin
        vectors++;
        if (loop_active_o !== 3'b010) begin
          miscompares++;
          $display("FAIL shared_inner_exit got act=%b want 010", loop_active_o);
        end
      end
      model_pc = exp_seq[i];
    end
    vectors++;
    if (loop_active_o !== 3'b000) begin
      miscompares++;
      $display("FAIL shared_final_act got %b want 000", loop_active_o);
    end
  endtask

  task automatic test_zero_iter();
    do_clear();
    retire(1'b1, 10'd10, 1'b0, 2'd0, '0, '0);
    retire(1'b0, '0, 1'b1, 2'd2, 10'd0, 10'd20);
    vectors++;
    if (pc_o !== 10'd21 || loop_active_o !== 3'b000 || error_o !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_iter got pc=%0d act=%b err=%b want pc=21 act=000 err=0",
               pc_o, loop_active_o, error_o);
    end
  endtask

  task automatic test_jump_in_loop();
    do_clear();
    retire(1'b1, 10'd2, 1'b0, 2'd0, '0, '0);
    retire(1'b0, '0, 1'b1, 2'd0, 10'd2, 10'd5);
    retire(1'b1, 10'd5, 1'b0, 2'd0, '0, '0);
    vectors++;
    if (pc_o !== 10'd5 || loop_active_o !== 3'b001) begin
      miscompares++;
      $display("FAIL jump_in_loop got pc=%0d act=%b want pc=5 act=001", pc_o, loop_active_o);
    end
    plain();
    vectors++;
    if (pc_o !== 10'd3 || loop_active_o !== 3'b001) begin
      miscompares++;
      $display("FAIL jump_backedge got pc=%0d act=%b want pc=3 act=001", pc_o, loop_active_o);
    end
    repeat (3) plain();
    vectors++;
    if (pc_o !== 10'd6 || loop_active_o !== 3'b000) begin
      miscompares++;
      $display("FAIL jump_exit got pc=%0d act=%b want pc=6 act=000", pc_o, loop_active_o);
    end
  endtask

  task automatic test_errors();
    do_clear();
    retire(1'b0, '0, 1'b1, 2'd3, 10'd4, 10'd9);
    vectors++;
    if (pc_o !== 10'd1 || error_o !== 1'b1 || loop_active_o !== 3'b000) begin
      miscompares++;
      $display("FAIL err_level3 got pc=%0d err=%b act=%b want pc=1 err=1 act=000",
               pc_o, error_o, loop_active_o);
    end
    do_clear();
    retire(1'b1, 10'd7, 1'b1, 2'd0, 10'd4, 10'd9);
    vectors++;
    if (pc_o !== 10'd7 || error_o !== 1'b1 || loop_active_o !== 3'b000) begin
      miscompares++;
      $display("FAIL err_jmp_setup got pc=%0d err=%b act=%b want pc=7 err=1 act=000",
               pc_o, error_o, loop_active_o);
    end
    plain();
    vectors++;
    if (error_o !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky got %b want 1", error_o);
    end
    do_clear();
    vectors++;
    if (pc_o !== 10'd0 || error_o !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clear got pc=%0d err=%b want pc=0 err=0", pc_o, error_o);
    end
    retire(1'b0, '0, 1'b1, 2'd0, 10'd2, 10'd0);
    vectors++;
    if (pc_o !== 10'd1 || error_o !== 1'b1 || loop_active_o !== 3'b001) begin
      miscompares++;
      $display("FAIL err_end_before got pc=%0d err=%b act=%b want pc=1 err=1 act=001",
               pc_o, error_o, loop_active_o);
    end
  endtask

  task automatic test_reset_mid_loop();
    do_clear();
    retire(1'b0, '0, 1'b1, 2'd1, 10'd3, 10'd5);
    plain();
    @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    vectors++;
    if (pc_o !== 10'd0 || loop_active_o !== 3'b000) begin
      miscompares++;
      $display("FAIL async_reset got pc=%0d act=%b want pc=0 act=000", pc_o, loop_active_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    retire(1'b0, '0, 1'b1, 2'd2, 10'd3, 10'd5);
    do_clear();
    vectors++;
    if (pc_o !== 10'd0 || loop_active_o !== 3'b000) begin
      miscompares++;
      $display("FAIL clear_mid_loop got pc=%0d act=%b want pc=0 act=000", pc_o, loop_active_o);
    end
  endtask

  task automatic test_stall_wrap();
    do_clear();
    retire(1'b1, 10'd7, 1'b0, 2'd0, '0, '0);
    @(negedge clk_i);
    jmp_valid_i   = 1'b1;
    jmp_target_i  = 10'd3;
    setup_valid_i = 1'b1;
    setup_level_i = 2'd3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      #1;
      vectors++;
      if (pc_o !== 10'd7 || error_o !== 1'b0) begin
        miscompares++;
        $display("FAIL stall%0d got pc=%0d err=%b want pc=7 err=0", i, pc_o, error_o);
      end
    end
    idle_inputs();
    retire(1'b1, 10'd1023, 1'b0, 2'd0, '0, '0);
    vectors++;
    if (pc_o !== 10'd1023) begin
      miscompares++;
      $display("FAIL wrap_jump got %0d want 1023", pc_o);
    end
    plain();
    vectors++;
    if (pc_o !== 10'd0) begin
      miscompares++;
      $display("FAIL wrap got %0d want 0", pc_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_loop();
    test_shared_end();
    test_zero_iter();
    test_jump_in_loop();
    test_errors();
    test_reset_mid_loop();
    test_stall_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ucode_loop_ctrl.md
# ucode_loop_ctrl

Program-counter and hardware-loop controller for the HD accelerator's microcode sequencer. It holds the microcode PC and three nested zero-overhead loop levels (0 innermost, 2 outermost), and applies jumps and loop setups as the decoder retires instructions. It sits between the microcode memory address port and the instruction decoder. The decoder reports each retired instruction's control-flow effect, and this block returns the next fetch address.

## Interface
Parameters:
- ADDR_WIDTH, 10: microcode address width; must equal the loop end-address operand width.
- ITER_WIDTH, 10: loop iteration count width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous restart. Returns the block to its reset state; has priority over all other inputs.
- en_i  in  1  the instruction at pc_o retires this cycle; the PC advances.
- jmp_valid_i  in  1  the retiring instruction is a jump.
- jmp_target_i  in  ADDR_WIDTH  jump target.
- setup_valid_i  in  1  the retiring instruction is a loop setup.
- setup_level_i  in  2  loop level, 0..2; value 3 is illegal.
- setup_iter_i  in  ITER_WIDTH  number of body executions.
- setup_end_i  in  ADDR_WIDTH  inclusive body end address.
- pc_o  out  ADDR_WIDTH  current fetch address (registered).
- loop_active_o  out  3  per-level active flag.
- error_o  out  1  sticky illegal-use flag.

## Operation
Per-level state: active, start (ADDR_WIDTH), end (ADDR_WIDTH), remaining (ITER_WIDTH).

- `jmp_valid_i`, `setup_valid_i` and `setup_*` are sampled only when `en_i` is high. When `en_i` is low, all state holds.
- **Jump.** On `en_i & jmp_valid_i`, pc <= jmp_target_i. Loop state is unchanged; loop-end checks are skipped that cycle.
- **Setup.** On `en_i & setup_valid_i` at PC = S, with L = setup_level_i and N = setup_iter_i:
  - N > 0: level L <= {active=1, start=S+1, end=setup_end_i, remaining=N}; pc <= S+1.
  - N = 0: level L stays or becomes inactive; pc <= setup_end_i+1, skipping the body.
  - Setting up an already-active level overwrites it.
- **Sequential.** Applies when `en_i` is high with neither valid asserted. Levels are evaluated 0, 1, 2 in order, considering only active levels whose end equals pc:
  - First matching level with remaining > 1: remaining <= remaining-1; pc <= its start. Evaluation stops.
  - Matching level with remaining = 1: active <= 0, remaining <= 0. Evaluation continues to the next level. This lets nested loops share one end address.
  - No level loops back: pc <= pc+1.
- **Arithmetic.** All address increments wrap modulo 2^ADDR_WIDTH.
- **Errors.** The following set `error_o`, which stays set until reset or `clear_i`:
  - `setup_valid_i & jmp_valid_i` together with `en_i`. Jump wins; the setup is discarded.
  - setup_level_i = 3. The setup is ignored; pc <= pc+1.
  - Setup with N > 0 and setup_end_i < S+1 (unsigned). The setup is still applied as specified.

## Timing
- **Reset/clear values.** pc_o = 0, loop_active_o = 3'b000, error_o = 0, all counters 0.
- **Latency.** Every state update takes effect on the rising edge where `en_i` is high; pc_o reflects the new address in the next cycle.
- **No combinational paths** from inputs to outputs.
- **Loop overhead.** Zero cycles: the back-edge is taken on the same edge that retires the end instruction.
- **Reset mid-loop.** Asserting rst_ni low asynchronously clears all state. Asserting clear_i clears it on the next edge, regardless of en_i.

## Test plan
- **Single loop.** Setup L0, N=3, end=5 at PC 2. Retire every cycle → PC sequence 2,3,4,5,3,4,5,3,4,5,6; loop_active_o[0] falls after the third retire of PC 5.
- **Shared end.** L1 N=2 end=8 at PC 4, then L0 N=2 end=8 at PC 5. Retire continuously → body 6..8 runs 4 times total, then PC 9; both flags low.
- **Zero iterations.** Setup L2, N=0, end=20 at PC 10 → next pc_o = 21, loop_active_o = 0.
- **Jump inside loop.** In an active L0 (end=5), jump to 5 from PC 3 → PC 5; the loop-end check on the next retire decrements normally.
- **Errors.** setup_level_i=3 with en_i → error_o=1, pc+1. Setup and jump together → pc = target, error_o=1. Then clear_i → pc_o=0, error_o=0.
- **Stall and wrap.** en_i low for 5 cycles → pc_o stable. Jump to 1023 and retire once → pc_o = 0.
